// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample-history controller: default sizes,
// controller state encoding and the active-low SRAM strobe levels.
package fir_pkg;

  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 6;
  localparam int NTAPS_DEF = 16;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_e;

  // SRAM strobes are active-low.
  localparam logic CEN_ACTIVE = 1'b0;
  localparam logic CEN_IDLE   = 1'b1;
  localparam logic WEN_WRITE  = 1'b0;
  localparam logic WEN_READ   = 1'b1;

endpackage

// File: rtl/fir_tap_addr_gen.sv
// Modulo-NTAPS down-counter walking the history buffer from the newest
// sample to the oldest; flags the final tap of the walk.
module fir_tap_addr_gen
  import fir_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int NTAPS = NTAPS_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic          dec_i,
  output logic [AW-1:0] next_addr_o,
  output logic          last_o
);

  localparam logic [AW-1:0] ADDR_MAX = AW'(NTAPS - 1);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] idx_q, idx_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_addr_o = (addr_q == '0) ? ADDR_MAX : addr_q - 1'b1;
    last_o      = (idx_q == ADDR_MAX);
    addr_d      = addr_q;
    idx_d       = idx_q;
    if (load_i) begin
      addr_d = load_addr_i;
      idx_d  = '0;
    end else if (dec_i) begin
      addr_d = next_addr_o;
      idx_d  = idx_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      addr_q <= '0;
      idx_q  <= '0;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/fir_mem_ctrl.sv
// Single-port SRAM initiator for the FIR: writes each sample into a circular
// history and replays the NTAPS newest samples, newest first, to the MAC.
module fir_mem_ctrl
  import fir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int NTAPS = NTAPS_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          MEM_CEN,
  output logic          MEM_WEN,
  output logic [AW-1:0] MEM_A,
  output logic [DW-1:0] MEM_D,
  input  logic [DW-1:0] MEM_Q
);

  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   CLR_END  = CW'(NTAPS);
  localparam logic [AW-1:0]   PTR_MAX  = AW'(NTAPS - 1);

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] clr_cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          mem_cen_q;
  logic          mem_wen_q;
  logic [AW-1:0] mem_a_q;
  logic [DW-1:0] mem_d_q;

  logic          gen_load;
  logic          gen_dec;
  logic [AW-1:0] gen_next;
  logic          gen_last;

  assign gen_load = (state_q == ST_WRITE);
  assign gen_dec  = (state_q == ST_READ) && !gen_last;

  fir_tap_addr_gen #(
    .AW    (AW),
    .NTAPS (NTAPS)
  ) u_tap_addr_gen (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .load_i      (gen_load),
    .load_addr_i (wr_ptr_q),
    .dec_i       (gen_dec),
    .next_addr_o (gen_next),
    .last_o      (gen_last)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= ST_CLEAR;
      wr_ptr_q    <= '0;
      clr_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      mem_cen_q   <= CEN_IDLE;
      mem_wen_q   <= WEN_READ;
      mem_a_q     <= '0;
      mem_d_q     <= '0;
    end else begin
      case (state_q)
        // NOTE: the SRAM array itself has no reset; the history is zeroed by
        // walking every used address with explicit writes.
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_END) begin
            mem_cen_q  <= CEN_IDLE;
            mem_wen_q  <= WEN_READ;
            mem_a_q    <= '0;
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            mem_cen_q <= CEN_ACTIVE;
            mem_wen_q <= WEN_WRITE;
            mem_a_q   <= clr_cnt_q[AW-1:0];
            mem_d_q   <= '0;
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            mem_cen_q  <= CEN_ACTIVE;
            mem_wen_q  <= WEN_WRITE;
            mem_a_q    <= wr_ptr_q;
            mem_d_q    <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Tap 0 reads back the slot just written; the SRAM returns new data.
          mem_cen_q <= CEN_ACTIVE;
          mem_wen_q <= WEN_READ;
          mem_a_q   <= wr_ptr_q;
          state_q   <= ST_READ;
        end
        ST_READ: begin
          out_valid_q <= 1'b1;
          out_last_q  <= gen_last;
          if (gen_last) begin
            mem_cen_q <= CEN_IDLE;
            state_q   <= ST_DRAIN;
          end else begin
            mem_a_q <= gen_next;
          end
        end
        ST_DRAIN: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          wr_ptr_q    <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = MEM_Q;
  assign MEM_CEN   = mem_cen_q;
  assign MEM_WEN   = mem_wen_q;
  assign MEM_A     = mem_a_q;
  assign MEM_D     = mem_d_q;

endmodule

// File: tb/tb_fir_mem_ctrl.sv
// Bench for fir_mem_ctrl: behavioural SRAM, history-buffer reference model
// with cycle-stamped expectations, random and directed sample streams.
module tb_fir_mem_ctrl;
  import fir_pkg::*;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NT = 4;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          MEM_CEN;
  logic          MEM_WEN;
  logic [AW-1:0] MEM_A;
  logic [DW-1:0] MEM_D;
  logic [DW-1:0] MEM_Q;

  always #5 CLK = ~CLK;

  fir_mem_ctrl #(
    .DW    (DW),
    .AW    (AW),
    .NTAPS (NT)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .MEM_CEN   (MEM_CEN),
    .MEM_WEN   (MEM_WEN),
    .MEM_A     (MEM_A),
    .MEM_D     (MEM_D),
    .MEM_Q     (MEM_Q)
  );

  // Behavioural SRAM, preloaded with garbage so the clear pass matters.
  logic [DW-1:0] mem [1<<AW];
  logic          mem_init = 1'b0;
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'($urandom);
      mem_init <= 1'b1;
    end else if (MEM_CEN == CEN_ACTIVE) begin
      if (MEM_WEN == WEN_WRITE) mem[MEM_A] <= MEM_D;
      else                      MEM_Q <= mem[MEM_A];
    end
  end

  typedef struct {
    int            cyc;
    int            a;
    logic [DW-1:0] d;
    logic          last;
  } ev_t;

  ev_t           wr_q[$];
  ev_t           rd_q[$];
  ev_t           tap_q[$];
  logic [DW-1:0] hist [NT];
  int            wptr;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;
  bit            thr_mode = 1'b0;
  int            thr_hs = 0;
  int            thr_rdy = 0;
  int            last_hs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) hist[i] = '0;
    wptr = 0;
    wr_q.delete();
    rd_q.delete();
    tap_q.delete();
  endtask

  // Monitor: samples on the falling edge and compares against cycle-stamped
  // expectations produced by the history model at each handshake.
  initial begin
    ev_t e;
    bit  exp_p;
    bit  obs_p;
    int  a;
    forever begin
      @(negedge CLK);
      cyc++;
      if (mon_en) begin
        exp_p = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
        obs_p = (MEM_CEN == CEN_ACTIVE) && (MEM_WEN == WEN_WRITE);
        check("wr_present", obs_p, exp_p);
        if (exp_p) begin
          e = wr_q.pop_front();
          if (obs_p) begin
            check("wr_addr", MEM_A, e.a);
            check("wr_data", MEM_D, e.d);
          end
        end

        exp_p = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
        obs_p = (MEM_CEN == CEN_ACTIVE) && (MEM_WEN == WEN_READ);
        check("rd_present", obs_p, exp_p);
        if (exp_p) begin
          e = rd_q.pop_front();
          if (obs_p) check("rd_addr", MEM_A, e.a);
        end

        exp_p = (tap_q.size() > 0) && (tap_q[0].cyc == cyc);
        check("tap_valid", out_valid, exp_p);
        if (exp_p) begin
          e = tap_q.pop_front();
          if (out_valid) begin
            check("tap_data", out_data, e.d);
            check("tap_last", out_last, e.last);
          end
        end else begin
          check("last_idle", out_last, 1'b0);
        end

        check("idle_access", in_ready && (MEM_CEN == CEN_ACTIVE), 1'b0);

        if (thr_mode && in_ready) thr_rdy++;

        // Handshake completes at the next rising edge.
        if (RSTN && in_valid && in_ready) begin
          hist[wptr] = in_data;
          wr_q.push_back('{cyc + 1, wptr, in_data, 1'b0});
          for (int j = 0; j < NT; j++) begin
            a = (wptr - j + NT) % NT;
            rd_q.push_back('{cyc + 2 + j, a, '0, 1'b0});
            tap_q.push_back('{cyc + 3 + j, 0, hist[a], j == NT - 1});
          end
          wptr = (wptr + 1) % NT;
          if (thr_mode) begin
            if (thr_hs > 0) check("thr_gap", cyc - last_hs, NT + 3);
            last_hs = cyc;
            thr_hs++;
          end
        end
      end
    end
  end

  task automatic do_reset();
    int n;
    bit done;
    mon_en   = 1'b0;
    RSTN     = 1'b0;
    in_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", in_ready, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_cen", MEM_CEN, CEN_IDLE);
    check("rst_wen", MEM_WEN, WEN_READ);
    check("rst_addr", MEM_A, 0);
    check("rst_data", MEM_D, 0);
    @(posedge CLK);
    #1 RSTN = 1'b1;
    n = 0;
    done = 1'b0;
    for (int t = 0; t < 3 * NT + 8 && !done; t++) begin
      @(negedge CLK);
      if (MEM_CEN == CEN_ACTIVE) begin
        check("clr_wen", MEM_WEN, WEN_WRITE);
        check("clr_addr", MEM_A, n);
        check("clr_data", MEM_D, 0);
        check("clr_ready", in_ready, 1'b0);
        n++;
      end else if (in_ready) begin
        done = 1'b1;
      end
    end
    check("clr_count", n, NT);
    check("clr_done", done, 1'b1);
    model_reset();
    mon_en = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    bit ok = 1'b0;
    @(posedge CLK);
    #1;
    in_valid = 1'b1;
    in_data  = v;
    for (int t = 0; t < 4 * NT + 20; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    check("send_ready", ok, 1'b1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int t = 0; t < 4 * NT + 20; t++) begin
      @(posedge CLK);
      #1;
      if (tap_q.size() == 0 && rd_q.size() == 0 && wr_q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("sample_done", ok, 1'b1);
  endtask

  initial begin
    bit ok;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    do_reset();

    // First sample, then wrap of the circular history.
    send(16'd100);
    wait_done();
    for (int i = 2; i <= 5; i++) begin
      send(DW'(i * 100));
      wait_done();
    end

    // Continuous offer: handshakes must be NT+3 cycles apart.
    @(posedge CLK);
    #1;
    thr_hs   = 0;
    thr_rdy  = 0;
    thr_mode = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1000;
    for (int s = 0; s < 6; s++) begin
      ok = 1'b0;
      for (int t = 0; t < 4 * NT + 20; t++) begin
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
        @(posedge CLK);
        #1;
      end
      check("thr_ready", ok, 1'b1);
      @(posedge CLK);
      #1;
      in_data = in_data + 1'b1;
    end
    in_valid = 1'b0;
    thr_mode = 1'b0;
    check("thr_count", thr_hs, 6);
    check("thr_pulse", thr_rdy, thr_hs);
    wait_done();

    // Random samples with random gaps; zero gaps offer while busy.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      send(DW'($urandom));
    end
    wait_done();

    // Reset during tap 2 of a sample, then history must restart at zero.
    send(16'hBEEF);
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    RSTN = 1'b0;
    @(posedge CLK);
    #1;
    mon_en = 1'b0;
    @(negedge CLK);
    check("mr_valid", out_valid, 1'b0);
    check("mr_cen", MEM_CEN, CEN_IDLE);
    check("mr_ready", in_ready, 1'b0);
    do_reset();
    send(16'd7);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
